// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered round-robin multiplexer.
// Mode encodings and a width helper that stays legal for tiny channel counts.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // $clog2(1) is 0, which would collapse index vectors to zero width.
   function automatic int safe_clog2(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first requester strictly
// after `last`, wrapping to channel 0.
module rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      grant       = '0;
      grant_valid = 1'b0;
      for (int off = 1; off <= N_CH; off++) begin
         if (!grant_valid && req[(int'(last) + off) % N_CH]) begin
            grant       = SEL_W'((int'(last) + off) % N_CH);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input registered mux with per-channel valid/ready, selectable between a
// software-fixed channel and round-robin arbitration.
module mux_nx1_rr
   import mux_pkg::*;
#(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = safe_clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic [SEL_W-1:0]  last_q,      last_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic              out_valid_q, out_valid_d;

   logic [SEL_W-1:0]  rr_grant;
   logic              rr_grant_valid;
   logic [SEL_W-1:0]  grant;
   logic              grant_valid;
   logic              fix_valid;
   logic              load;
   logic              xfer;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .req         (in_valid),
      .last        (last_q),
      .grant       (rr_grant),
      .grant_valid (rr_grant_valid)
   );

   always_comb begin
      // An out-of-range sel (non power-of-two N_CH) simply never grants.
      fix_valid = 1'b0;
      if (int'(sel) < N_CH) begin
         fix_valid = in_valid[sel];
      end

      if (mode == MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_grant_valid;
      end else begin
         grant       = sel;
         grant_valid = fix_valid;
      end

      load = !out_valid_q || out_ready;
      xfer = !rst && load && grant_valid;

      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = xfer && (int'(grant) == i);
      end

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      if (load) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = in_data[int'(grant)*DATA_W +: DATA_W];
            out_ch_d   = grant;
            if (mode == MODE_RR) begin
               last_d = grant;
            end
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= SEL_W'(N_CH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule
